// File: rtl/mem_stage_unit.sv
// MEM-stage unit: registers FU0/FU1 results, executes FU2 loads/stores against
// a word-organised data RAM, and drives a three-lane completion bus.
module mem_stage_unit #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  tunnel_in,
  input  logic [31:0] rd_result_fu0_in,
  input  logic [31:0] pc_fu0_in,
  input  logic [31:0] rd_result_fu1_in,
  input  logic [31:0] pc_fu1_in,
  input  logic [31:0] rd_result_fu2_in,
  input  logic [31:0] pc_fu2_in,
  input  logic [31:0] store_data_in,
  input  logic        op_write_in,
  input  logic        op_read_in,
  input  logic        op_in,
  output logic [2:0]  cmpl_valid,
  output logic [31:0] cmpl_value0,
  output logic [31:0] cmpl_value1,
  output logic [31:0] cmpl_value2,
  output logic [31:0] cmpl_pc0,
  output logic [31:0] cmpl_pc1,
  output logic [31:0] cmpl_pc2,
  output logic        misalign_err,
  output logic        illegal_err,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    bsel;
  logic          is_illegal, is_load, is_store, is_misalign;
  logic          do_load, do_store;
  logic [31:0]   rdata, rshift, wdata;
  logic [7:0]    rbyte;
  logic [3:0]    be;
  logic [31:0]   value2_c;

  assign idx  = rd_result_fu2_in[AW+1:2];
  assign bsel = rd_result_fu2_in[1:0];

  // FU2 operation decode; an invalid lane never touches RAM or counters
  always_comb begin
    is_illegal  = tunnel_in[2] & op_read_in & op_write_in;
    is_load     = tunnel_in[2] & op_read_in & ~op_write_in;
    is_store    = tunnel_in[2] & op_write_in & ~op_read_in;
    is_misalign = (is_load | is_store) & op_in & (bsel != 2'b00);
    do_load     = is_load & ~is_misalign;
    do_store    = is_store & ~is_misalign;
  end

  // Read side: RAM word sampled at the capture edge, byte lane sign-extended
  always_comb begin
    rdata  = mem[idx];
    rshift = rdata >> {bsel, 3'b000};
    rbyte  = rshift[7:0];
    value2_c = rd_result_fu2_in;
    if (is_illegal || is_store || is_misalign) begin
      value2_c = 32'h0;
    end else if (do_load) begin
      value2_c = op_in ? rdata : {{24{rbyte[7]}}, rbyte};
    end
  end

  // Write side: byte stores replicate the data byte and enable a single lane
  always_comb begin
    be    = op_in ? 4'hF : 4'(4'b0001 << bsel);
    wdata = op_in ? store_data_in : {4{store_data_in[7:0]}};
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Completion, error and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmpl_valid   <= 3'b000;
      cmpl_value0  <= 32'h0;
      cmpl_value1  <= 32'h0;
      cmpl_value2  <= 32'h0;
      cmpl_pc0     <= 32'h0;
      cmpl_pc1     <= 32'h0;
      cmpl_pc2     <= 32'h0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      load_cnt     <= 32'h0;
      store_cnt    <= 32'h0;
    end else begin
      cmpl_valid   <= tunnel_in;
      cmpl_value0  <= rd_result_fu0_in;
      cmpl_value1  <= rd_result_fu1_in;
      cmpl_value2  <= value2_c;
      cmpl_pc0     <= pc_fu0_in;
      cmpl_pc1     <= pc_fu1_in;
      cmpl_pc2     <= pc_fu2_in;
      misalign_err <= is_misalign;
      illegal_err  <= is_illegal;
      if (do_load)  load_cnt  <= load_cnt + 32'd1;
      if (do_store) store_cnt <= store_cnt + 32'd1;
    end
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. Sits directly after that register and before ROB/writeback.
- Passes the FU0/FU1 ALU results through one registered stage.
- Executes FU2 load/store operations against an internal word-organised data RAM.
- Presents an aligned three-lane completion bus, one cycle after capture, with per-lane valids, plus error flags and load/store counters.

Parameters:
- DEPTH, 256, number of 32-bit words in the data RAM (power of two).
- AW, 8, word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- tunnel_in  in  3  lane-valid bits: bit0 = FU0, bit1 = FU1, bit2 = FU2.
- rd_result_fu0_in  in  32  FU0 result.
- pc_fu0_in  in  32  FU0 instruction PC.
- rd_result_fu1_in  in  32  FU1 result.
- pc_fu1_in  in  32  FU1 instruction PC.
- rd_result_fu2_in  in  32  FU2 effective byte address for mem ops; otherwise the FU2 result.
- pc_fu2_in  in  32  FU2 instruction PC.
- store_data_in  in  32  FU2 store data.
- op_write_in  in  1  FU2 store request.
- op_read_in  in  1  FU2 load request.
- op_in  in  1  access size: 1 = word, 0 = byte.
- cmpl_valid  out  3  completion valid per lane.
- cmpl_value0, cmpl_value1, cmpl_value2  out  32 each  completion values.
- cmpl_pc0, cmpl_pc1, cmpl_pc2  out  32 each  completion PCs.
- misalign_err  out  1  pulse: FU2 word access with addr[1:0] != 0.
- illegal_err  out  1  pulse: op_read_in and op_write_in both set.
- load_cnt  out  32  number of completed loads.
- store_cnt  out  32  number of committed stores.

Behaviour:
- Reset (rstn low, asynchronous): all cmpl_*, both err flags and both counters go to 0. RAM contents are not reset and survive reset.
- Latency: every lane completes exactly 1 cycle after capture. An input at edge N appears on the outputs after edge N+1. No backpressure; one op per lane per cycle.
- FU0/FU1 lanes:
  - cmpl_valid[i] <= tunnel_in[i].
  - Value and PC are registered. They are don't-care while invalid, but are still loaded every cycle.
- FU2 classification, evaluated when tunnel_in[2]=1:
  - Both op flags set: illegal. illegal_err=1, no RAM access, lane completes with value 0.
  - op_read_in only: load.
  - op_write_in only: store.
  - Neither set: ALU result passed through like FU0.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Word access (op_in=1) with addr[1:0] != 0: misalign_err=1, no write, load returns 0. The lane still completes and counters do not increment.
- Load:
  - Synchronous RAM read; data is ready at N+1.
  - Byte load selects byte lane addr[1:0] (little-endian) and sign-extends it to 32 bits.
  - load_cnt increments on completion.
- Store:
  - RAM written at edge N.
  - Byte store writes only byte lane addr[1:0] through a byte-enable; other bytes are unchanged.
  - Store completes at N+1 with value 0. store_cnt increments.
- Ordering: a load issued in the cycle after a store to the same word returns the new data. The write lands before the read edge, so no forwarding is required.
- Error flags are single-cycle pulses aligned with the lane-2 completion.
- Counters wrap at 2^32.
- tunnel_in[2]=0 blocks RAM access and counting regardless of the op flags.
- Reset mid-operation: any in-flight completion is dropped and no late valid is produced. A store captured at the same edge at which reset asserts is not guaranteed to land.

Test Plan:
- Reset, then tunnel_in=3'b011, fu0=0x11, fu1=0x22 -> next cycle cmpl_valid=3'b011, values 0x11/0x22, PCs match.
- sw addr 0x10 data 0xDEADBEEF; next cycle lw 0x10 -> lw completion value 0xDEADBEEF, store_cnt=1, load_cnt=1.
- sb addr 0x13 data 0x80 over word 0x00000000; lb 0x13 -> 0xFFFFFF80; lw 0x10 -> 0x80000000.
- lw addr 0x12 -> misalign_err pulses 1 cycle, value 0, load_cnt unchanged.
- op_read_in=op_write_in=1 with tunnel bit2 -> illegal_err pulse, RAM unchanged.
- Ops with tunnel_in=0 -> no completions, counters unchanged.
- Assert rstn mid-stream -> outputs and counters 0 immediately; previously stored data still readable after release.
